// File: rtl/kick_sequencer_if.sv
// Kicker sequencer signal bundle: request side (radio/auto-kick),
// sensor inputs, and power-stage/status outputs.
interface kick_sequencer_if;
   logic       enable;
   logic       cap_full;
   logic       ir;
   logic       cmd_req;
   logic [2:0] cmd_strength;
   logic       auto_req;
   logic [2:0] auto_strength;
   logic       cmd_ack;
   logic       auto_ack;
   logic       charge_en;
   logic       fire;
   logic       ready;
   logic       busy;
   logic       kick_done;
   logic       timeout;
   logic [7:0] kick_count;

   // Requester / environment side
   modport master (
      output enable, cap_full, ir, cmd_req, cmd_strength, auto_req, auto_strength,
      input  cmd_ack, auto_ack, charge_en, fire, ready, busy, kick_done, timeout,
             kick_count
   );

   // Sequencer side
   modport slave (
      input  enable, cap_full, ir, cmd_req, cmd_strength, auto_req, auto_strength,
      output cmd_ack, auto_ack, charge_en, fire, ready, busy, kick_done, timeout,
             kick_count
   );
endinterface

// File: rtl/kick_sequencer.sv
// Kicker power-stage sequencer: charge, arbitrate kick requests, wait for
// the ball, fire a bounded solenoid pulse, then cool down before recharging.
// All outputs are registered and decoded from the next state.
module kick_sequencer #(
   parameter int unsigned CHARGE_CYCLES   = 1000000,
   parameter int unsigned FIRE_UNIT       = 50000,
   parameter int unsigned COOLDOWN_CYCLES = 200000,
   parameter int unsigned ARM_TIMEOUT     = 5000000
) (
   input logic              clk,
   input logic              rst_n,
   kick_sequencer_if.slave  bus
);

   function automatic int unsigned max2(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

   localparam int unsigned FIRE_MAX = 7 * FIRE_UNIT;
   localparam int unsigned CNT_MAX  = max2(max2(CHARGE_CYCLES, FIRE_MAX),
                                           max2(COOLDOWN_CYCLES, ARM_TIMEOUT));
   localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] CHARGE_LAST = CNT_W'(CHARGE_CYCLES - 1);
   localparam logic [CNT_W-1:0] COOL_LAST   = CNT_W'(COOLDOWN_CYCLES - 1);
   localparam logic [CNT_W-1:0] ARM_LAST    = CNT_W'(ARM_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] FIRE_UNIT_C = CNT_W'(FIRE_UNIT);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CHARGING,
      S_READY,
      S_ARMED,
      S_FIRE,
      S_COOLDOWN
   } state_t;

   state_t           r_state;
   state_t           w_state_next;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_next;
   logic [CNT_W-1:0] w_fire_last;
   logic [2:0]       r_strength;
   logic             w_cmd_valid;
   logic             w_auto_valid;
   logic             w_accept_cmd;
   logic             w_accept_auto;
   logic             w_timeout;
   logic             w_kick_done;

   logic             r_cmd_ack;
   logic             r_auto_ack;
   logic             r_charge_en;
   logic             r_fire;
   logic             r_ready;
   logic             r_busy;
   logic             r_kick_done;
   logic             r_timeout;
   logic [7:0]       r_kick_count;

   assign w_cmd_valid  = bus.cmd_req  && (bus.cmd_strength  != 3'd0);
   assign w_auto_valid = bus.auto_req && (bus.auto_strength != 3'd0);
   assign w_fire_last  = CNT_W'(r_strength) * FIRE_UNIT_C - CNT_W'(1);

   // Next-state, arbitration and event decode; enable=0 overrides everything
   always_comb begin
      w_state_next  = r_state;
      w_accept_cmd  = 1'b0;
      w_accept_auto = 1'b0;
      w_timeout     = 1'b0;
      w_kick_done   = 1'b0;
      if (!bus.enable) begin
         w_state_next = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:     w_state_next = S_CHARGING;
            S_CHARGING: if (bus.cap_full || (r_cnt == CHARGE_LAST)) w_state_next = S_READY;
            S_READY: begin
               if (w_cmd_valid) begin
                  w_accept_cmd = 1'b1;
                  w_state_next = S_ARMED;
               end else if (w_auto_valid) begin
                  w_accept_auto = 1'b1;
                  w_state_next  = S_ARMED;
               end
            end
            S_ARMED: begin
               if (bus.ir) begin
                  w_state_next = S_FIRE;
               end else if (r_cnt == ARM_LAST) begin
                  w_timeout    = 1'b1;
                  w_state_next = S_CHARGING;
               end
            end
            S_FIRE: begin
               if (r_cnt == w_fire_last) begin
                  w_kick_done  = 1'b1;
                  w_state_next = S_COOLDOWN;
               end
            end
            S_COOLDOWN: if (r_cnt == COOL_LAST) w_state_next = S_CHARGING;
            default:    w_state_next = S_IDLE;
         endcase
      end
   end

   // Shared counter: clears on any state entry, counts only in timed states
   always_comb begin
      w_cnt_next = r_cnt;
      if (w_state_next != r_state) begin
         w_cnt_next = '0;
      end else if ((r_state == S_CHARGING) || (r_state == S_ARMED) ||
                   (r_state == S_FIRE)     || (r_state == S_COOLDOWN)) begin
         w_cnt_next = r_cnt + CNT_W'(1);
      end
   end

   // State, counter, latched strength and next-state-decoded registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         r_strength   <= '0;
         r_cmd_ack    <= 1'b0;
         r_auto_ack   <= 1'b0;
         r_charge_en  <= 1'b0;
         r_fire       <= 1'b0;
         r_ready      <= 1'b0;
         r_busy       <= 1'b0;
         r_kick_done  <= 1'b0;
         r_timeout    <= 1'b0;
         r_kick_count <= '0;
      end else begin
         r_state     <= w_state_next;
         r_cnt       <= w_cnt_next;
         if (w_accept_cmd) begin
            r_strength <= bus.cmd_strength;
         end else if (w_accept_auto) begin
            r_strength <= bus.auto_strength;
         end
         r_cmd_ack   <= w_accept_cmd;
         r_auto_ack  <= w_accept_auto;
         r_charge_en <= (w_state_next == S_CHARGING) || (w_state_next == S_READY);
         r_fire      <= (w_state_next == S_FIRE);
         r_ready     <= (w_state_next == S_READY);
         r_busy      <= (w_state_next == S_ARMED) || (w_state_next == S_FIRE) ||
                        (w_state_next == S_COOLDOWN);
         r_kick_done <= w_kick_done;
         r_timeout   <= w_timeout;
         if (w_kick_done && (r_kick_count != '1)) begin
            r_kick_count <= r_kick_count + 8'd1;
         end
      end
   end

   assign bus.cmd_ack    = r_cmd_ack;
   assign bus.auto_ack   = r_auto_ack;
   assign bus.charge_en  = r_charge_en;
   assign bus.fire       = r_fire;
   assign bus.ready      = r_ready;
   assign bus.busy       = r_busy;
   assign bus.kick_done  = r_kick_done;
   assign bus.timeout    = r_timeout;
   assign bus.kick_count = r_kick_count;

endmodule

// File: tb/tb_kick_sequencer.sv
// Directed bench for kick_sequencer with short timing parameters:
// CHARGE_CYCLES=20, FIRE_UNIT=4, COOLDOWN_CYCLES=10, ARM_TIMEOUT=50.
module tb_kick_sequencer;
   logic        clk = 1'b0;
   logic        rst_n;
   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;
   bit          mon_on   = 1'b0;
   int unsigned w;

   kick_sequencer_if bus();

   kick_sequencer #(
      .CHARGE_CYCLES  (20),
      .FIRE_UNIT      (4),
      .COOLDOWN_CYCLES(10),
      .ARM_TIMEOUT    (50)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus.slave)
   );

   // 10-unit clock
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Advance n rising edges and settle just past the last one
   task automatic step(input int unsigned n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Count consecutive samples with fire high (bounded)
   task automatic fire_width(output int unsigned wid);
      wid = 0;
      while (bus.fire && wid < 100) begin
         wid++;
         step(1);
      end
   endtask

   // One complete strength-1 host kick with ball present
   task automatic do_kick();
      int unsigned n;
      n = 0;
      while (!bus.ready && n < 100) begin
         step(1);
         n++;
      end
      chk("kick_ready", 32'(bus.ready), 1);
      bus.cmd_strength = 3'd1;
      bus.cmd_req      = 1'b1;
      step(1);
      chk("kick_ack", 32'(bus.cmd_ack), 1);
      bus.cmd_req = 1'b0;
      n = 0;
      while (!bus.kick_done && n < 100) begin
         step(1);
         n++;
      end
      chk("kick_done", 32'(bus.kick_done), 1);
   endtask

   // Mutual exclusion of charger and solenoid, every cycle
   always @(negedge clk) begin
      if (mon_on) chk("excl", 32'(bus.charge_en & bus.fire), 0);
   end

   // Global time bound
   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n             = 1'b0;
      bus.enable        = 1'b1;
      bus.cap_full      = 1'b0;
      bus.ir            = 1'b0;
      bus.cmd_req       = 1'b0;
      bus.cmd_strength  = 3'd0;
      bus.auto_req      = 1'b0;
      bus.auto_strength = 3'd0;
      step(2);
      chk("rst_charge", 32'(bus.charge_en), 0);
      chk("rst_fire", 32'(bus.fire), 0);
      chk("rst_ready", 32'(bus.ready), 0);
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_count", 32'(bus.kick_count), 0);
      mon_on = 1'b1;

      // 1: charge timeout after 20 cycles
      rst_n = 1'b1;
      step(1);
      for (int unsigned i = 0; i < 20; i++) begin
         chk("chg_en", 32'(bus.charge_en), 1);
         chk("chg_not_ready", 32'(bus.ready), 0);
         step(1);
      end
      chk("chg_ready", 32'(bus.ready), 1);
      // 1b: cap_full at cycle 5
      bus.enable = 1'b0;
      step(1);
      chk("idle_charge", 32'(bus.charge_en), 0);
      chk("idle_ready", 32'(bus.ready), 0);
      bus.enable = 1'b1;
      step(1);
      chk("chg2_en", 32'(bus.charge_en), 1);
      step(4);
      chk("chg2_not_ready", 32'(bus.ready), 0);
      bus.cap_full = 1'b1;
      step(1);
      chk("capfull_ready", 32'(bus.ready), 1);

      // 2: strength-3 host kick with ball present
      bus.ir           = 1'b1;
      bus.cmd_strength = 3'd3;
      bus.cmd_req      = 1'b1;
      step(1);
      chk("k2_ack", 32'(bus.cmd_ack), 1);
      chk("k2_busy", 32'(bus.busy), 1);
      chk("k2_armed_charge", 32'(bus.charge_en), 0);
      chk("k2_armed_fire", 32'(bus.fire), 0);
      bus.cmd_req = 1'b0;
      step(1);
      chk("k2_ack_pulse", 32'(bus.cmd_ack), 0);
      for (int unsigned i = 0; i < 12; i++) begin
         chk("k2_fire", 32'(bus.fire), 1);
         chk("k2_no_done", 32'(bus.kick_done), 0);
         step(1);
      end
      chk("k2_fire_end", 32'(bus.fire), 0);
      chk("k2_done", 32'(bus.kick_done), 1);
      chk("k2_count", 32'(bus.kick_count), 1);
      for (int unsigned i = 0; i < 10; i++) begin
         chk("k2_cool_charge", 32'(bus.charge_en), 0);
         chk("k2_cool_busy", 32'(bus.busy), 1);
         if (i == 1) chk("k2_done_pulse", 32'(bus.kick_done), 0);
         step(1);
      end
      chk("k2_recharge", 32'(bus.charge_en), 1);
      step(1);
      chk("k2_ready", 32'(bus.ready), 1);

      // 3: simultaneous requests, host wins
      bus.cmd_strength  = 3'd2;
      bus.auto_strength = 3'd5;
      bus.cmd_req       = 1'b1;
      bus.auto_req      = 1'b1;
      step(1);
      chk("arb_cmd_ack", 32'(bus.cmd_ack), 1);
      chk("arb_auto_ack", 32'(bus.auto_ack), 0);
      bus.cmd_req  = 1'b0;
      bus.auto_req = 1'b0;
      step(1);
      fire_width(w);
      chk("arb_fire_width", w, 8);
      step(10);
      step(1);
      chk("arb_ready", 32'(bus.ready), 1);
      chk("arb_count", 32'(bus.kick_count), 2);
      // 3b: strength 0 ignored
      bus.cmd_strength = 3'd0;
      bus.cmd_req      = 1'b1;
      step(1);
      chk("s0_ack", 32'(bus.cmd_ack), 0);
      chk("s0_ready", 32'(bus.ready), 1);
      step(1);
      chk("s0_busy", 32'(bus.busy), 0);
      bus.cmd_req = 1'b0;

      // 4: arm timeout without ball (auto path)
      bus.ir            = 1'b0;
      bus.auto_strength = 3'd5;
      bus.auto_req      = 1'b1;
      step(1);
      chk("to_auto_ack", 32'(bus.auto_ack), 1);
      chk("to_cmd_ack", 32'(bus.cmd_ack), 0);
      bus.auto_req = 1'b0;
      for (int unsigned i = 0; i < 50; i++) begin
         chk("to_busy", 32'(bus.busy), 1);
         chk("to_not_yet", 32'(bus.timeout), 0);
         chk("to_no_fire", 32'(bus.fire), 0);
         step(1);
      end
      chk("to_pulse", 32'(bus.timeout), 1);
      chk("to_recharge", 32'(bus.charge_en), 1);
      step(1);
      chk("to_pulse_end", 32'(bus.timeout), 0);
      chk("to_ready", 32'(bus.ready), 1);
      // 4b: ball arrives at cycle 30
      bus.cmd_strength = 3'd1;
      bus.cmd_req      = 1'b1;
      step(1);
      chk("late_ack", 32'(bus.cmd_ack), 1);
      bus.cmd_req = 1'b0;
      step(29);
      chk("late_no_fire", 32'(bus.fire), 0);
      bus.ir = 1'b1;
      step(1);
      fire_width(w);
      chk("late_fire_width", w, 4);
      step(10);
      step(1);
      chk("late_ready", 32'(bus.ready), 1);
      chk("late_count", 32'(bus.kick_count), 3);

      // 5: abort mid-FIRE, then async reset mid-CHARGING
      bus.cmd_strength = 3'd7;
      bus.cmd_req      = 1'b1;
      step(1);
      chk("ab_ack", 32'(bus.cmd_ack), 1);
      bus.cmd_req = 1'b0;
      step(1);
      chk("ab_fire1", 32'(bus.fire), 1);
      step(9);
      chk("ab_fire10", 32'(bus.fire), 1);
      bus.enable = 1'b0;
      step(1);
      chk("ab_fire_off", 32'(bus.fire), 0);
      chk("ab_charge_off", 32'(bus.charge_en), 0);
      chk("ab_no_done", 32'(bus.kick_done), 0);
      chk("ab_busy", 32'(bus.busy), 0);
      step(1);
      chk("ab_no_done2", 32'(bus.kick_done), 0);
      chk("ab_count", 32'(bus.kick_count), 3);
      bus.cap_full = 1'b0;
      bus.enable   = 1'b1;
      step(1);
      chk("ar_charging", 32'(bus.charge_en), 1);
      step(3);
      #2 rst_n = 1'b0;
      #1;
      chk("ar_charge", 32'(bus.charge_en), 0);
      chk("ar_ready", 32'(bus.ready), 0);
      chk("ar_busy", 32'(bus.busy), 0);
      chk("ar_count", 32'(bus.kick_count), 0);
      step(1);
      bus.cap_full = 1'b1;
      rst_n        = 1'b1;

      // 6: saturation over 260 kicks
      bus.ir = 1'b1;
      for (int unsigned k = 1; k <= 260; k++) begin
         do_kick();
         if (k == 1)   chk("sat_count1", 32'(bus.kick_count), 1);
         if (k == 254) chk("sat_count254", 32'(bus.kick_count), 254);
         if (k == 255) chk("sat_count255", 32'(bus.kick_count), 255);
         if (k == 260) chk("sat_count260", 32'(bus.kick_count), 255);
      end

      mon_on = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
